// File: rtl/complex_scheduler.sv
// Issue queue and sequencer for the multiply/divide complex unit.
// Defining COMPLEX_SCHED_PERF_EN adds the perf_issued_o and perf_stall_o counters.
module complex_scheduler #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 6,
    parameter int PRF_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             enq_valid_i,
    output logic             enq_ready_o,
    input  logic [2:0]       enq_opcode_i,
    input  logic [31:0]      enq_op1_i,
    input  logic [31:0]      enq_op2_i,
    input  logic [TAG_W-1:0] enq_rob_tag_i,
    input  logic [PRF_W-1:0] enq_dest_i,
    output logic             cu_valid_o,
    output logic [2:0]       cu_opcode_o,
    output logic [31:0]      cu_operand1_o,
    output logic [31:0]      cu_operand2_o,
    input  logic             cu_busy_i,
    input  logic [31:0]      cu_result_i,
    input  logic             cu_wb_valid_i,
    output logic             wb_valid_o,
    output logic [31:0]      wb_result_o,
    output logic [TAG_W-1:0] wb_rob_tag_o,
    output logic [PRF_W-1:0] wb_dest_o
`ifdef COMPLEX_SCHED_PERF_EN
    ,
    output logic [31:0]      perf_issued_o,
    output logic [31:0]      perf_stall_o
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t           state;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;

    logic [2:0]       opc_mem  [DEPTH];
    logic [31:0]      op1_mem  [DEPTH];
    logic [31:0]      op2_mem  [DEPTH];
    logic [TAG_W-1:0] tag_mem  [DEPTH];
    logic [PRF_W-1:0] dest_mem [DEPTH];

    logic do_enq;
    logic do_pop;
    logic head_active;

    assign enq_ready_o = (count != (PTR_W+1)'(DEPTH));
    assign do_enq      = enq_valid_i && enq_ready_o && !flush_i;
    assign do_pop      = (state == WAIT) && cu_wb_valid_i && !flush_i;

    // The head entry stays put until completion pops it, so the unit can re-read it.
    assign head_active   = (state != IDLE);
    assign cu_valid_o    = (state == ISSUE);
    assign cu_opcode_o   = head_active ? opc_mem[head] : 3'b000;
    assign cu_operand1_o = head_active ? op1_mem[head] : 32'd0;
    assign cu_operand2_o = head_active ? op2_mem[head] : 32'd0;

    always_ff @(posedge clk_i) begin
        if (do_enq) begin
            opc_mem[tail]  <= enq_opcode_i;
            op1_mem[tail]  <= enq_op1_i;
            op2_mem[tail]  <= enq_op2_i;
            tag_mem[tail]  <= enq_rob_tag_i;
            dest_mem[tail] <= enq_dest_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            wb_valid_o   <= 1'b0;
            wb_result_o  <= '0;
            wb_rob_tag_o <= '0;
            wb_dest_o    <= '0;
        end else if (flush_i) begin
            state      <= IDLE;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            wb_valid_o <= 1'b0;
        end else begin
            wb_valid_o <= do_pop;
            if (do_enq) begin
                tail <= tail + 1'b1;
            end
            if (do_pop) begin
                head         <= head + 1'b1;
                wb_result_o  <= cu_result_i;
                wb_rob_tag_o <= tag_mem[head];
                wb_dest_o    <= dest_mem[head];
            end
            if (do_enq && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_enq && do_pop) begin
                count <= count - 1'b1;
            end
            case (state)
                IDLE:    if (count != '0 && !cu_busy_i) state <= ISSUE;
                ISSUE:   state <= WAIT;
                WAIT:    if (cu_wb_valid_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef COMPLEX_SCHED_PERF_EN
    // Counters deliberately ignore flush so they span the whole run.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_issued_o <= '0;
            perf_stall_o  <= '0;
        end else begin
            if (state == ISSUE) begin
                perf_issued_o <= perf_issued_o + 32'd1;
            end
            if (state == IDLE && count != '0 && cu_busy_i) begin
                perf_stall_o <= perf_stall_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_complex_scheduler.sv
// Scoreboard bench for complex_scheduler with a behavioural mul/div unit model.
module tb_complex_scheduler;

    localparam int DEPTH = 4;
    localparam int TAG_W = 6;
    localparam int PRF_W = 6;
    localparam int LAT   = 4;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             flush_i;
    logic             enq_valid_i;
    logic             enq_ready_o;
    logic [2:0]       enq_opcode_i;
    logic [31:0]      enq_op1_i;
    logic [31:0]      enq_op2_i;
    logic [TAG_W-1:0] enq_rob_tag_i;
    logic [PRF_W-1:0] enq_dest_i;
    logic             cu_valid_o;
    logic [2:0]       cu_opcode_o;
    logic [31:0]      cu_operand1_o;
    logic [31:0]      cu_operand2_o;
    logic             cu_busy_i;
    logic [31:0]      cu_result_i;
    logic             cu_wb_valid_i;
    logic             wb_valid_o;
    logic [31:0]      wb_result_o;
    logic [TAG_W-1:0] wb_rob_tag_o;
    logic [PRF_W-1:0] wb_dest_o;
`ifdef COMPLEX_SCHED_PERF_EN
    logic [31:0]      perf_issued_o;
    logic [31:0]      perf_stall_o;
`endif

    complex_scheduler #(.DEPTH(DEPTH), .TAG_W(TAG_W), .PRF_W(PRF_W)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .flush_i       (flush_i),
        .enq_valid_i   (enq_valid_i),
        .enq_ready_o   (enq_ready_o),
        .enq_opcode_i  (enq_opcode_i),
        .enq_op1_i     (enq_op1_i),
        .enq_op2_i     (enq_op2_i),
        .enq_rob_tag_i (enq_rob_tag_i),
        .enq_dest_i    (enq_dest_i),
        .cu_valid_o    (cu_valid_o),
        .cu_opcode_o   (cu_opcode_o),
        .cu_operand1_o (cu_operand1_o),
        .cu_operand2_o (cu_operand2_o),
        .cu_busy_i     (cu_busy_i),
        .cu_result_i   (cu_result_i),
        .cu_wb_valid_i (cu_wb_valid_i),
        .wb_valid_o    (wb_valid_o),
        .wb_result_o   (wb_result_o),
        .wb_rob_tag_o  (wb_rob_tag_o),
        .wb_dest_o     (wb_dest_o)
`ifdef COMPLEX_SCHED_PERF_EN
        ,
        .perf_issued_o (perf_issued_o),
        .perf_stall_o  (perf_stall_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
        logic [PRF_W-1:0] dest;
    } exp_t;

    exp_t sb[$];
    int   total     = 0;
    int   bad       = 0;
    int   issue_cnt = 0;

    logic        unit_busy  = 1'b0;
    logic        force_busy = 1'b0;
    logic        u_active   = 1'b0;
    logic        u_drain    = 1'b0;
    int          u_cnt      = 0;
    logic [2:0]  u_opc;
    logic [31:0] u_a;
    logic [31:0] u_b;

    assign cu_busy_i = unit_busy | force_busy;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] unit_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[2]) return a * b;
        if (!op[1]) return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
        return (b == 32'd0) ? a : a % b;
    endfunction

    // Unit model: latches the issued op, then re-reads the ports every cycle until it completes.
    initial begin
        cu_wb_valid_i = 1'b0;
        cu_result_i   = 32'd0;
        forever begin
            @(negedge clk_i);
            cu_wb_valid_i = 1'b0;
            if (rst_i) begin
                u_active  = 1'b0;
                u_drain   = 1'b0;
                unit_busy = 1'b0;
            end else if (cu_valid_o) begin
                issue_cnt++;
                checkOutput("issue_to_idle_unit", 32'(unit_busy), 32'd0);
                u_opc     = cu_opcode_o;
                u_a       = cu_operand1_o;
                u_b       = cu_operand2_o;
                u_active  = 1'b1;
                u_cnt     = LAT;
                unit_busy = 1'b1;
            end else if (u_active) begin
                if (flush_i) begin
                    u_active = 1'b0;
                    u_drain  = 1'b1;
                    u_cnt    = 3;
                end else begin
                    checkOutput("hold_opcode", 32'(cu_opcode_o), 32'(u_opc));
                    checkOutput("hold_op1", cu_operand1_o, u_a);
                    checkOutput("hold_op2", cu_operand2_o, u_b);
                    u_cnt--;
                    if (u_cnt == 0) begin
                        cu_result_i   = unit_calc(u_opc, u_a, u_b);
                        cu_wb_valid_i = 1'b1;
                        u_active      = 1'b0;
                        unit_busy     = 1'b0;
                    end
                end
            end else if (u_drain) begin
                u_cnt--;
                if (u_cnt == 0) begin
                    u_drain   = 1'b0;
                    unit_busy = 1'b0;
                end
            end
        end
    end

    // Writeback monitor: every wb_valid_o pulse must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge clk_i);
            if (!rst_i && wb_valid_o) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_wb", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("wb_result", wb_result_o, e.res);
                    checkOutput("wb_tag", 32'(wb_rob_tag_o), 32'(e.tag));
                    checkOutput("wb_dest", 32'(wb_dest_o), 32'(e.dest));
                end
            end
        end
    end

    task automatic applyStimulus(input logic [2:0] opc, input logic [31:0] a, input logic [31:0] b,
                                 input logic [TAG_W-1:0] tag, input logic [PRF_W-1:0] dest,
                                 input logic [31:0] exp_res);
        int   guard;
        exp_t e;
        guard         = 0;
        enq_valid_i   = 1'b1;
        enq_opcode_i  = opc;
        enq_op1_i     = a;
        enq_op2_i     = b;
        enq_rob_tag_i = tag;
        enq_dest_i    = dest;
        do begin
            @(negedge clk_i);
            guard++;
        end while (!enq_ready_o && guard < 200);
        if (!enq_ready_o) begin
            checkOutput("enq_timeout", 32'd0, 32'd1);
        end else begin
            e.res  = exp_res;
            e.tag  = tag;
            e.dest = dest;
            sb.push_back(e);
        end
        @(posedge clk_i);
        #1;
        enq_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while ((sb.size() != 0 || u_active || u_drain) && guard < 1000) begin
            @(negedge clk_i);
            guard++;
        end
        if (guard >= 1000) checkOutput("drain_timeout", 32'd0, 32'd1);
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_issue();
        int guard;
        guard = 0;
        do begin
            @(negedge clk_i);
            guard++;
        end while (!cu_valid_o && guard < 200);
        if (!cu_valid_o) checkOutput("issue_timeout", 32'd0, 32'd1);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   base;
        int   guard;
        exp_t e;
`ifdef COMPLEX_SCHED_PERF_EN
        logic [31:0] iss0;
        logic [31:0] st0;
`endif
        rst_i         = 1'b1;
        flush_i       = 1'b0;
        enq_valid_i   = 1'b0;
        enq_opcode_i  = 3'd0;
        enq_op1_i     = 32'd0;
        enq_op2_i     = 32'd0;
        enq_rob_tag_i = '0;
        enq_dest_i    = '0;
        #1;
        checkOutput("rst_enq_ready", 32'(enq_ready_o), 32'd1);
        checkOutput("rst_cu_valid", 32'(cu_valid_o), 32'd0);
        checkOutput("rst_wb_valid", 32'(wb_valid_o), 32'd0);
        checkOutput("rst_count", 32'(dut.count), 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Single multiply
        base = issue_cnt;
        applyStimulus(3'b000, 32'd7, 32'd6, 6'd5, 6'd9, 32'd42);
        wait_drain();
        checkOutput("mul_issues", 32'(issue_cnt - base), 32'd1);
        checkOutput("mul_count_zero", 32'(dut.count), 32'd0);

        // Divide and remainder by zero
        base = issue_cnt;
        applyStimulus(3'b100, 32'd100, 32'd0, 6'd1, 6'd2, 32'hFFFF_FFFF);
        applyStimulus(3'b110, 32'd100, 32'd0, 6'd3, 6'd4, 32'd100);
        wait_drain();
        checkOutput("div0_issues", 32'(issue_cnt - base), 32'd2);

        // Back-to-back fill to full
        base = issue_cnt;
        applyStimulus(3'b100, 32'd100, 32'd7, 6'd10, 6'd20, 32'd14);
        applyStimulus(3'b000, 32'd3,   32'd3, 6'd11, 6'd21, 32'd9);
        applyStimulus(3'b110, 32'd100, 32'd7, 6'd12, 6'd22, 32'd2);
        applyStimulus(3'b000, 32'd0,   32'd5, 6'd13, 6'd23, 32'd0);
        checkOutput("full_ready_low", 32'(enq_ready_o), 32'd0);
        wait_drain();
        checkOutput("b2b_issues", 32'(issue_cnt - base), 32'd4);
        checkOutput("b2b_ready_high", 32'(enq_ready_o), 32'd1);

        // Flush while the first divide is in flight
        base = issue_cnt;
        applyStimulus(3'b100, 32'd50, 32'd5, 6'd14, 6'd24, 32'd10);
        applyStimulus(3'b100, 32'd60, 32'd6, 6'd15, 6'd25, 32'd10);
        wait_issue();
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        sb.delete();
        checkOutput("flush_count", 32'(dut.count), 32'd0);
        checkOutput("flush_ready", 32'(enq_ready_o), 32'd1);
        checkOutput("flush_cu_opcode", 32'(cu_opcode_o), 32'd0);
        checkOutput("flush_cu_op1", cu_operand1_o, 32'd0);
        applyStimulus(3'b000, 32'd11, 32'd12, 6'd16, 6'd26, 32'd132);
        wait_drain();
        checkOutput("flush_issues", 32'(issue_cnt - base), 32'd2);

        // Enqueue and completion in the same cycle at DEPTH-1 entries
        base = issue_cnt;
        applyStimulus(3'b000, 32'd2, 32'd3, 6'd17, 6'd27, 32'd6);
        applyStimulus(3'b000, 32'd4, 32'd5, 6'd18, 6'd28, 32'd20);
        applyStimulus(3'b000, 32'd6, 32'd7, 6'd19, 6'd29, 32'd42);
        guard = 0;
        do begin
            @(negedge clk_i);
            #2;
            guard++;
        end while (!cu_wb_valid_i && guard < 200);
        if (!cu_wb_valid_i) checkOutput("completion_timeout", 32'd0, 32'd1);
        checkOutput("sim_count_before", 32'(dut.count), 32'(DEPTH - 1));
        enq_valid_i   = 1'b1;
        enq_opcode_i  = 3'b000;
        enq_op1_i     = 32'd8;
        enq_op2_i     = 32'd9;
        enq_rob_tag_i = 6'd20;
        enq_dest_i    = 6'd30;
        e.res  = 32'd72;
        e.tag  = 6'd20;
        e.dest = 6'd30;
        sb.push_back(e);
        @(posedge clk_i);
        #1;
        enq_valid_i = 1'b0;
        checkOutput("sim_count_after", 32'(dut.count), 32'(DEPTH - 1));
        wait_drain();
        checkOutput("sim_issues", 32'(issue_cnt - base), 32'd4);

`ifdef COMPLEX_SCHED_PERF_EN
        // Perf counters: two forced-busy stall cycles across three ops
        iss0       = perf_issued_o;
        st0        = perf_stall_o;
        force_busy = 1'b1;
        applyStimulus(3'b000, 32'd2, 32'd2, 6'd21, 6'd31, 32'd4);
        @(posedge clk_i);
        #1;
        @(posedge clk_i);
        #1;
        force_busy = 1'b0;
        applyStimulus(3'b000, 32'd3, 32'd4, 6'd22, 6'd32, 32'd12);
        applyStimulus(3'b100, 32'd9, 32'd3, 6'd23, 6'd33, 32'd3);
        wait_drain();
        checkOutput("perf_issued", perf_issued_o - iss0, 32'd3);
        checkOutput("perf_stall", perf_stall_o - st0, 32'd2);
`endif

        // Asynchronous reset in the middle of WAIT
        applyStimulus(3'b001, 32'd5, 32'd9, 6'd24, 6'd34, 32'd45);
        wait_issue();
        #2;
        rst_i = 1'b1;
        #1;
        sb.delete();
        checkOutput("arst_cu_valid", 32'(cu_valid_o), 32'd0);
        checkOutput("arst_cu_opcode", 32'(cu_opcode_o), 32'd0);
        checkOutput("arst_cu_op1", cu_operand1_o, 32'd0);
        checkOutput("arst_cu_op2", cu_operand2_o, 32'd0);
        checkOutput("arst_wb_valid", 32'(wb_valid_o), 32'd0);
        checkOutput("arst_wb_result", wb_result_o, 32'd0);
        checkOutput("arst_wb_tag", 32'(wb_rob_tag_o), 32'd0);
        checkOutput("arst_wb_dest", 32'(wb_dest_o), 32'd0);
        checkOutput("arst_ready", 32'(enq_ready_o), 32'd1);
        checkOutput("arst_count", 32'(dut.count), 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        repeat (2) @(posedge clk_i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
